// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_rx
// Brief    : Receive-only PS/2 keyboard deserialiser with Set-2 prefix decoding
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 24000
) (
  input  logic       CLK12,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       KEY_STROBE,
  output logic       KEY_PRESSED,
  output logic       KEY_EXTENDED,
  output logic [7:0] KEY_CODE,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR
);

  localparam int c_FILT_W = $clog2(FILTER_LEN + 1);
  localparam int c_TOUT_W = $clog2(TIMEOUT_CYC);
  localparam logic [c_FILT_W-1:0] c_FLEN = c_FILT_W'(FILTER_LEN);
  localparam logic [c_TOUT_W-1:0] c_TMAX = c_TOUT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic                r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
  logic                r_clk_filt;
  logic [c_FILT_W-1:0] r_filt_cnt;
  logic                r_sample;
  logic                r_bit;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_bitcnt, w_bitcnt_nxt;
  logic [7:0]          r_sr, w_sr_nxt;
  logic                r_par, w_par_nxt;
  logic [c_TOUT_W-1:0] r_tcnt, w_tcnt_nxt;
  logic                r_byte_valid, w_byte_valid_nxt;
  logic                w_perr_nxt, w_ferr_nxt;

  logic                r_ext, r_rel;
  logic [2:0]          r_skip;

  // Synchroniser and clock glitch filter; a filtered falling edge is one sample event
  always_ff @(posedge CLK12) begin
    if (RESET) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
      r_sample   <= 1'b0;
      r_bit      <= 1'b1;
    end else begin
      r_clk_meta <= PS2_CLK;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= PS2_DATA;
      r_dat_sync <= r_dat_meta;
      r_sample   <= 1'b0;
      if (r_clk_sync == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == c_FLEN) begin
        r_clk_filt <= r_clk_sync;
        r_filt_cnt <= '0;
        r_sample   <= r_clk_filt;
        r_bit      <= r_dat_sync;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK12) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_bitcnt     <= '0;
      r_sr         <= '0;
      r_par        <= 1'b0;
      r_tcnt       <= '0;
      r_byte_valid <= 1'b0;
      PARITY_ERR   <= 1'b0;
      FRAME_ERR    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_sr         <= w_sr_nxt;
      r_par        <= w_par_nxt;
      r_tcnt       <= w_tcnt_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      PARITY_ERR   <= w_perr_nxt;
      FRAME_ERR    <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_bitcnt_nxt     = r_bitcnt;
    w_sr_nxt         = r_sr;
    w_par_nxt        = r_par;
    w_byte_valid_nxt = 1'b0;
    w_perr_nxt       = 1'b0;
    w_ferr_nxt       = 1'b0;
    w_tcnt_nxt       = r_sample ? '0 : ((r_tcnt == c_TMAX) ? r_tcnt : r_tcnt + 1'b1);

    case (r_state)
      S_IDLE: begin
        if (r_sample && !r_bit) begin
          w_state_nxt  = S_DATA;
          w_bitcnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (r_sample) begin
          w_sr_nxt     = {r_bit, r_sr[7:1]};
          w_bitcnt_nxt = r_bitcnt + 1'b1;
          if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (r_sample) begin
          w_par_nxt   = r_bit;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_sample) begin
          if (r_bit && (^{r_sr, r_par})) w_byte_valid_nxt = 1'b1;
          else                           w_perr_nxt       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A sample event in the same cycle keeps the frame alive
    if (!r_sample && (r_state != S_IDLE) && (r_tcnt == c_TMAX - 1'b1)) begin
      w_state_nxt = S_IDLE;
      w_ferr_nxt  = 1'b1;
    end
  end

  // Set-2 prefix layer; r_sr still holds the byte in the cycle after the stop bit
  always_ff @(posedge CLK12) begin
    if (RESET) begin
      KEY_STROBE   <= 1'b0;
      KEY_PRESSED  <= 1'b0;
      KEY_EXTENDED <= 1'b0;
      KEY_CODE     <= 8'h00;
      r_ext        <= 1'b0;
      r_rel        <= 1'b0;
      r_skip       <= '0;
    end else begin
      KEY_STROBE <= 1'b0;
      if (PARITY_ERR || FRAME_ERR) begin
        r_ext  <= 1'b0;
        r_rel  <= 1'b0;
        r_skip <= '0;
      end else if (r_byte_valid) begin
        if (r_skip != 3'd0) begin
          r_skip <= r_skip - 1'b1;
        end else begin
          case (r_sr)
            8'hE0: r_ext <= 1'b1;
            8'hF0: r_rel <= 1'b1;
            8'hE1: begin
              r_skip <= 3'd7;
              r_ext  <= 1'b0;
              r_rel  <= 1'b0;
            end
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
              r_ext <= 1'b0;
              r_rel <= 1'b0;
            end
            default: begin
              KEY_STROBE   <= 1'b1;
              KEY_CODE     <= r_sr;
              KEY_EXTENDED <= r_ext;
              KEY_PRESSED  <= ~r_rel;
              r_ext        <= 1'b0;
              r_rel        <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire
